// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as start bit,
// LSB-first data, optional parity and one or two stop bits on a registered line.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_din_i,
  input  logic       tx_start_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       tx_done_tick_o,
  output logic       tx_active_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity;

  logic baud_wrap;
  logic last_bit;
  logic last_stop;

  assign baud_wrap = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  assign tx_ready_o     = (state == IDLE);
  assign tx_active_o    = (state != IDLE);
  assign tx_done_tick_o = (state == STOP) && baud_wrap && last_stop;

  // The line value is registered one cycle ahead of the state it belongs to,
  // so every transition also loads the level of the bit being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_o     <= 1'b1;
    end else begin
      if (state != IDLE) begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          tx_o     <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          if (tx_start_i) begin
            state  <= START;
            tx_o   <= 1'b0;
            shreg  <= tx_din_i[DATA_BITS-1:0];
            parity <= 1'b0;
          end
        end
        START: begin
          if (baud_wrap) begin
            state <= DATA;
            tx_o  <= shreg[0];
          end
        end
        DATA: begin
          if (baud_wrap) begin
            shreg  <= shreg >> 1;
            parity <= parity ^ shreg[0];
            if (last_bit) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_o  <= parity ^ shreg[0] ^ 1'(PARITY_ODD);
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_o    <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (baud_wrap) begin
            state <= STOP;
            tx_o  <= 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            if (last_stop) begin
              state    <= IDLE;
              stop_cnt <= 1'b0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one parallel byte per handshake into an asynchronous frame: start bit, data LSB first, optional parity, stop bit(s). It is the transmit-side counterpart of `uart_rx` and uses the same bit-period convention, so `tx_o` can be looped straight into `rx_i` of `uart_rx`. A valid/ready handshake on the parallel side lets a FIFO or register bank feed frames with no gaps.

## Interface
- `CLKS_PER_BIT`, 10: clock cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame; range 5–8.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.

- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `tx_din_i` in 8: byte to send; bits above `DATA_BITS`-1 are ignored.
- `tx_start_i` in 1: valid; a frame is accepted on a rising edge where `tx_start_i` && `tx_ready_o`.
- `tx_ready_o` out 1: high only in IDLE.
- `tx_o` out 1: serial line, registered, idle high.
- `tx_done_tick_o` out 1: one-cycle pulse in the last cycle of the final stop bit.
- `tx_active_o` out 1: high from the first start-bit cycle through the last stop-bit cycle.

## Operation
- Reset values:
  - `tx_o`=1, `tx_ready_o`=1, `tx_active_o`=0, `tx_done_tick_o`=0.
  - State is IDLE; all counters are 0.
- Datapath:
  - Shift register `shreg[DATA_BITS-1:0]`, bit counter, baud counter (0..`CLKS_PER_BIT`-1), stop counter, parity accumulator.
- FSM states:
  - IDLE: `tx_o`=1. On accept, latch `tx_din_i` into `shreg`, clear the parity accumulator, go to START.
  - START: `tx_o`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: `tx_o`=`shreg[0]`. At baud-counter wrap:
    - shift `shreg` right and XOR the sent bit into parity;
    - after `DATA_BITS` bits, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: `tx_o` = accumulated XOR ^ `PARITY_ODD` for one bit period, then STOP.
  - STOP: `tx_o`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. `tx_done_tick_o` is 1 in the final cycle; then IDLE.
- Baud counter:
  - clears on every state entry;
  - increments each cycle and wraps at `CLKS_PER_BIT`-1;
  - a bit ends on the wrap cycle.
- Frame data is frozen at accept. Changes on `tx_din_i` mid-frame have no effect.
- `tx_start_i` while `tx_ready_o`=0 is ignored; no queuing.
- Reset mid-frame:
  - the frame is aborted and the line returns to 1 the cycle after `rst_i` is sampled;
  - no `tx_done_tick_o` is generated;
  - the block is in IDLE, ready for a new accept, once `rst_i` deasserts.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

## Timing
- Accept at edge N:
  - `tx_o` falls and `tx_active_o` rises and `tx_ready_o` falls, all at edge N+1.
- Frame length F = (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles. Defaults: F = 100.
- `tx_done_tick_o` is high in cycle N+F.
- At edge N+F+1:
  - state is IDLE;
  - `tx_ready_o`=1;
  - `tx_active_o`=0.
- Back-to-back: holding `tx_start_i` high accepts the next frame at edge N+F+1. The next start bit begins at N+F+2, so there is exactly one extra idle-high cycle between frames.
- Data bit k (LSB = 0) is driven from cycle N+1+(1+k)×`CLKS_PER_BIT` for `CLKS_PER_BIT` cycles.

## Test plan
- Reset, then idle 20 cycles:
  - `tx_o`=1, `tx_ready_o`=1, `tx_active_o`=0, no done tick;
  - `tx_start_i` asserted during reset is not accepted.
- Defaults, send 0xAB:
  - line is 0,1,1,0,1,0,1,0,1,1, each exactly 10 cycles;
  - done tick at accept+100;
  - `tx_ready_o` high at accept+101.
- Send 0x00 then 0xFD with `tx_start_i` held high:
  - two frames separated by exactly 1 idle cycle;
  - loopback into `uart_rx` yields `rx_dout_o` 0x00 then 0xFD with two `rx_done_tick_o` pulses.
- `PARITY_EN`=1, `STOP_BITS`=2, send 0xAB (five ones):
  - even parity bit = 1; with `PARITY_ODD`=1, parity bit = 0;
  - frame is 120 cycles; stop high for 20 cycles.
- Mid-frame disturbance:
  - change `tx_din_i` to 0x55 and pulse `tx_start_i` during DATA: the frame still carries 0xAB and no second frame starts;
  - assert `rst_i` during bit 3: `tx_o`=1 next cycle, no done tick, next accepted byte sent correctly.
- `CLKS_PER_BIT`=2, `DATA_BITS`=5, send 0x1F:
  - line is 0,1,1,1,1,1,1, each bit 2 cycles;
  - total frame 14 cycles.
